alu_issue_decode: RTL and testbench
===================================

Name: alu_issue_decode

Overview:
- Decode/issue stage for the integer ALU path: takes raw RV32I instructions over a valid/ready handshake.
- Decodes OP, OP-IMM, LUI and AUIPC into an alu_pkg::alu_op_e opcode, register indices, an immediate and operand-select flags, then presents them to the execute stage over a registered valid/ready interface.
- Includes a 2-entry skid buffer so instr_ready_o is a registered signal, plus a saturating counter of illegal instructions.

Parameters:
- XLEN, 32, data/PC/immediate width; only 32 is supported.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- flush_i  in  1  synchronous flush; discards all buffered entries.
- instr_valid_i  in  1  instruction present.
- instr_ready_o  out  1  stage can accept an instruction.
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  PC of instr_i.
- dec_valid_o  out  1  decoded entry present.
- dec_ready_i  in  1  execute stage accepts the entry.
- alu_op_o  out  alu_op_e  ALU operation.
- rs1_o  out  5  source register 1; 0 for LUI/AUIPC.
- rs2_o  out  5  source register 2; 0 unless OP.
- rd_o  out  5  destination register.
- imm_o  out  XLEN  decoded immediate.
- use_imm_o  out  1  operand 2 is imm_o.
- use_pc_o  out  1  operand 1 is pc_o (AUIPC).
- pc_o  out  XLEN  PC of the entry.
- rd_we_o  out  1  write rd; 0 if illegal.
- illegal_o  out  1  entry is an illegal/unsupported instruction.
- illegal_cnt_o  out  CNT_W  count of accepted illegal instructions.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- During and after reset:
  - dec_valid_o = 0.
  - All decoded outputs = 0 (alu_op_o = ALU_ADD).
  - illegal_cnt_o = 0.
  - instr_ready_o = 1.
- Storage: main register (drives outputs) plus one skid register. instr_ready_o = !skid_valid, registered.
- Transfers:
  - Input transfer when instr_valid_i && instr_ready_o.
  - Output transfer when dec_valid_o && dec_ready_i.
- Latency and throughput:
  - Latency 1 cycle: an instruction accepted at edge N is on the outputs after edge N, provided the main register is empty or drains at N.
  - Throughput 1 per cycle while dec_ready_i = 1.
- Buffer update at each edge:
  - Main empty or draining: main loads the skid entry if one is held, otherwise the incoming entry.
  - Skid loads the incoming entry only when the main register is full and not draining.
  - When skid drains into main and an input is accepted in the same cycle, the input goes to skid.
- Ordering and stability:
  - Ordering is strictly preserved.
  - Outputs are stable while dec_valid_o && !dec_ready_i.
- flush_i:
  - At the edge, both entries are invalidated.
  - An input accepted in the same cycle is dropped and not counted.
  - instr_ready_o = 1 the next cycle.
  - Flush has priority over all transfers.
- Decode, opcode = instr[6:0], funct3 f3 = [14:12], funct7 f7 = [31:25]:
  - OP (0x33):
    - f3 000 → ADD (f7 = 0x00) / SUB (f7 = 0x20).
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
    - 101 → SRL (f7 = 0x00) / SRA (f7 = 0x20).
    - 110 OR; 111 AND.
    - f7 = 0x20 with any other f3, or f7 not in {0x00, 0x20}, is illegal.
  - OP-IMM (0x13):
    - imm_o = sign-extended instr[31:20]; use_imm_o = 1.
    - f3 000 ADD; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND.
    - Shifts: 001 SLLI requires f7 = 0x00. 101 is SRLI (f7 = 0x00) or SRAI (f7 = 0x20); any other f7 is illegal.
    - For shifts, imm_o = zero-extended shamt instr[24:20].
  - LUI (0x37): ALU_ADD, rs1_o = 0, imm_o = {instr[31:12], 12'b0}, use_imm_o = 1.
  - AUIPC (0x17): as LUI, plus use_pc_o = 1.
  - Any other opcode, including 0x00000000 and 0xFFFFFFFF, is illegal.
  - rd_we_o = legal; rd_o = instr[11:7] even when illegal.
- Illegal entries:
  - illegal_o = 1, alu_op_o = ALU_ADD, use_imm_o = 0, use_pc_o = 0, imm_o = 0, rd_we_o = 0.
  - The entry still flows through the handshake; it is not dropped.
- illegal_cnt_o:
  - Increments by 1 per accepted illegal instruction (at input transfer, not flushed).
  - Saturates at all-ones.
  - Cleared only by reset.

Test Plan:
- Reset → dec_valid_o = 0, instr_ready_o = 1, illegal_cnt_o = 0. Push 0x002081B3 (add x3,x1,x2) → next cycle dec_valid_o = 1, ALU_ADD, rs1 = 1, rs2 = 2, rd = 3, use_imm = 0, rd_we = 1.
- 0x402081B3 → ALU_SUB. 0xFFF00293 (addi x5,x0,-1) → ALU_ADD, imm_o = 0xFFFFFFFF, use_imm = 1, rd = 5. 0x4033D313 (srai x6,x7,3) → ALU_SRA, rs1 = 7, imm_o = 3.
- 0x123450B7 → LUI: ALU_ADD, rs1 = 0, imm_o = 0x12345000. Same encoding with opcode 0x17 (AUIPC) and pc_i = 0x100 → use_pc_o = 1, pc_o = 0x100.
- 0x0000006F, 0x00000000, and 0x022081B3 (funct7 0x01) → illegal_o = 1, rd_we_o = 0, illegal_cnt_o = 3. Preload counter near all-ones → stays at 0xFFFF.
- Backpressure: dec_ready_i = 0, push 3 back-to-back instructions → 2 buffered, instr_ready_o = 0 after the second, third held by source. Release → all three emerge in order, one per cycle, outputs stable while stalled.
- flush_i with both entries full while instr_valid_i = 1 → next cycle dec_valid_o = 0, instr_ready_o = 1, flushed-cycle input dropped and not counted. Assert rst_ni mid-stream → outputs clear immediately (asynchronously).

Source files
------------

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: RV32I integer-ALU decode/issue stage.
// The valid/ready input is backed by a main register plus one skid register,
// which keeps instr_ready_o a flop output. Illegal instructions are counted
// with a saturating counter.

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output alu_op_e          alu_op_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             use_imm_o,
  output logic             use_pc_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             rd_we_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef struct packed {
    alu_op_e         op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            use_pc;
    logic [XLEN-1:0] pc;
    logic            rd_we;
    logic            illegal;
  } entry_t;

  // Pure combinational decode of one instruction word into a pipeline entry.
  function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    entry_t     e;
    logic       legal;
    logic [2:0] f3;
    logic [6:0] f7;
    e     = '0;
    e.op  = ALU_ADD;
    e.pc  = pc;
    e.rd  = instr[11:7];
    f3    = instr[14:12];
    f7    = instr[31:25];
    legal = 1'b0;
    case (instr[6:0])
      7'h33: begin
        e.rs1 = instr[19:15];
        e.rs2 = instr[24:20];
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        case (f3)
          3'b000:  e.op = f7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  e.op = ALU_SLL;
          3'b010:  e.op = ALU_SLT;
          3'b011:  e.op = ALU_SLTU;
          3'b100:  e.op = ALU_XOR;
          3'b101:  e.op = f7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  e.op = ALU_OR;
          default: e.op = ALU_AND;
        endcase
      end
      7'h13: begin
        e.rs1     = instr[19:15];
        e.use_imm = 1'b1;
        e.imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
        legal     = 1'b1;
        case (f3)
          3'b000: e.op = ALU_ADD;
          3'b001: begin
            e.op  = ALU_SLL;
            e.imm = {{(XLEN-5){1'b0}}, instr[24:20]};
            legal = (f7 == 7'h00);
          end
          3'b010: e.op = ALU_SLT;
          3'b011: e.op = ALU_SLTU;
          3'b100: e.op = ALU_XOR;
          3'b101: begin
            e.op  = f7[5] ? ALU_SRA : ALU_SRL;
            e.imm = {{(XLEN-5){1'b0}}, instr[24:20]};
            legal = (f7 == 7'h00) || (f7 == 7'h20);
          end
          3'b110:  e.op = ALU_OR;
          default: e.op = ALU_AND;
        endcase
      end
      7'h37, 7'h17: begin
        e.use_imm = 1'b1;
        e.use_pc  = (instr[6:0] == 7'h17);
        e.imm     = {instr[31:12], 12'b0};
        legal     = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.op      = ALU_ADD;
      e.use_imm = 1'b0;
      e.use_pc  = 1'b0;
      e.imm     = '0;
    end else begin
      e.op = e.op;
    end
    e.illegal = !legal;
    e.rd_we   = legal;
    return e;
  endfunction

  entry_t           dec_s, main_r, skid_r, main_nxt_s, skid_nxt_s;
  logic             main_valid_r, skid_valid_r, main_valid_nxt_s, skid_valid_nxt_s;
  logic             ready_r, in_fire_s, main_free_s;
  logic [CNT_W-1:0] cnt_r;

  assign in_fire_s   = instr_valid_i && ready_r;
  assign main_free_s = !main_valid_r || dec_ready_i;

  // Decode the incoming instruction word.
  always_comb begin
    dec_s = decode(instr_i, pc_i);
  end

  // Next state of the main/skid pair; flush beats every transfer.
  always_comb begin
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush_i) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        main_nxt_s       = skid_r;
        main_valid_nxt_s = 1'b1;
        skid_valid_nxt_s = in_fire_s;
        if (in_fire_s) begin
          skid_nxt_s = dec_s;
        end else begin
          skid_nxt_s = skid_r;
        end
      end else if (in_fire_s) begin
        main_nxt_s       = dec_s;
        main_valid_nxt_s = 1'b1;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_nxt_s       = dec_s;
      skid_valid_nxt_s = 1'b1;
    end else begin
      skid_valid_nxt_s = skid_valid_r;
    end
  end

  // Buffer registers; ready is registered from the next skid occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      ready_r      <= !skid_valid_nxt_s;
    end
  end

  // Saturating count of accepted, non-flushed illegal instructions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else if (in_fire_s && !flush_i && dec_s.illegal && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign instr_ready_o = ready_r;
  assign dec_valid_o   = main_valid_r;
  assign alu_op_o      = main_r.op;
  assign rs1_o         = main_r.rs1;
  assign rs2_o         = main_r.rs2;
  assign rd_o          = main_r.rd;
  assign imm_o         = main_r.imm;
  assign use_imm_o     = main_r.use_imm;
  assign use_pc_o      = main_r.use_pc;
  assign pc_o          = main_r.pc;
  assign rd_we_o       = main_r.rd_we;
  assign illegal_o     = main_r.illegal;
  assign illegal_cnt_o = cnt_r;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Directed bench for alu_issue_decode: decode vectors, backpressure, flush,
// async reset, and counter saturation on a narrow-counter second instance.
module tb_alu_issue_decode;
  import alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, instr_valid_i, dec_ready_i;
  logic [31:0] instr_i, pc_i;

  logic        instr_ready_o, dec_valid_o, use_imm_o, use_pc_o, rd_we_o, illegal_o;
  alu_op_e     alu_op_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o, pc_o;
  logic [15:0] illegal_cnt_o;

  logic        s_ready, s_valid, s_use_imm, s_use_pc, s_rd_we, s_illegal;
  alu_op_e     s_op;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [31:0] s_imm, s_pc;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  alu_issue_decode #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .alu_op_o(alu_op_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .imm_o(imm_o), .use_imm_o(use_imm_o), .use_pc_o(use_pc_o), .pc_o(pc_o),
    .rd_we_o(rd_we_o), .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  alu_issue_decode #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(s_ready),
    .instr_i(instr_i), .pc_i(pc_i),
    .dec_valid_o(s_valid), .dec_ready_i(dec_ready_i),
    .alu_op_o(s_op), .rs1_o(s_rs1), .rs2_o(s_rs2), .rd_o(s_rd),
    .imm_o(s_imm), .use_imm_o(s_use_imm), .use_pc_o(s_use_pc), .pc_o(s_pc),
    .rd_we_o(s_rd_we), .illegal_o(s_illegal), .illegal_cnt_o(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the negedge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    pc_i          = pc;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; instr_valid_i = 1'b0; dec_ready_i = 1'b1;
    instr_i = 32'h0; pc_i = 32'h0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 32'(dec_valid_o), 32'd0);
    chk("rst_ready", 32'(instr_ready_o), 32'd1);
    chk("rst_cnt", 32'(illegal_cnt_o), 32'd0);
    chk("rst_op", 32'(alu_op_o), 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    rst_ni = 1'b1;
    step();
    chk("post_rst_valid", 32'(dec_valid_o), 32'd0);

    // add x3,x1,x2
    drive(32'h002081B3, 32'h0);
    step();
    chk("add_valid", 32'(dec_valid_o), 32'd1);
    chk("add_op", 32'(alu_op_o), 32'(ALU_ADD));
    chk("add_rs1", 32'(rs1_o), 32'd1);
    chk("add_rs2", 32'(rs2_o), 32'd2);
    chk("add_rd", 32'(rd_o), 32'd3);
    chk("add_use_imm", 32'(use_imm_o), 32'd0);
    chk("add_rd_we", 32'(rd_we_o), 32'd1);
    chk("add_illegal", 32'(illegal_o), 32'd0);

    drive(32'h402081B3, 32'h4);
    step();
    chk("sub_op", 32'(alu_op_o), 32'(ALU_SUB));
    chk("sub_pc", pc_o, 32'h4);

    // addi x5,x0,-1
    drive(32'hFFF00293, 32'h8);
    step();
    chk("addi_op", 32'(alu_op_o), 32'(ALU_ADD));
    chk("addi_imm", imm_o, 32'hFFFFFFFF);
    chk("addi_use_imm", 32'(use_imm_o), 32'd1);
    chk("addi_rd", 32'(rd_o), 32'd5);
    chk("addi_rs2", 32'(rs2_o), 32'd0);

    // srai x6,x7,3
    drive(32'h4033D313, 32'hC);
    step();
    chk("srai_op", 32'(alu_op_o), 32'(ALU_SRA));
    chk("srai_rs1", 32'(rs1_o), 32'd7);
    chk("srai_imm", imm_o, 32'd3);
    chk("srai_rd", 32'(rd_o), 32'd6);

    drive(32'h123450B7, 32'h10);
    step();
    chk("lui_op", 32'(alu_op_o), 32'(ALU_ADD));
    chk("lui_rs1", 32'(rs1_o), 32'd0);
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_use_pc", 32'(use_pc_o), 32'd0);
    chk("lui_rd", 32'(rd_o), 32'd1);

    drive(32'h12345097, 32'h100);
    step();
    chk("auipc_use_pc", 32'(use_pc_o), 32'd1);
    chk("auipc_pc", pc_o, 32'h100);
    chk("auipc_imm", imm_o, 32'h12345000);
    chk("auipc_use_imm", 32'(use_imm_o), 32'd1);

    drive(32'h0000006F, 32'h104);
    step();
    chk("jal_illegal", 32'(illegal_o), 32'd1);
    chk("jal_rd_we", 32'(rd_we_o), 32'd0);
    chk("cnt1", 32'(illegal_cnt_o), 32'd1);
    drive(32'h00000000, 32'h108);
    step();
    chk("zero_illegal", 32'(illegal_o), 32'd1);
    drive(32'h022081B3, 32'h10C);
    step();
    chk("f7_illegal", 32'(illegal_o), 32'd1);
    chk("f7_rd_we", 32'(rd_we_o), 32'd0);
    chk("f7_op", 32'(alu_op_o), 32'(ALU_ADD));
    chk("f7_rd", 32'(rd_o), 32'd3);
    chk("cnt3", 32'(illegal_cnt_o), 32'd3);
    chk("sat_cnt3", 32'(s_cnt), 32'd3);
    instr_valid_i = 1'b0;
    step();
    chk("drained", 32'(dec_valid_o), 32'd0);

    // Backpressure: A, B buffered, C held by source.
    dec_ready_i = 1'b0;
    drive(32'h002081B3, 32'h200);
    step();
    chk("bp_a_valid", 32'(dec_valid_o), 32'd1);
    chk("bp_ready1", 32'(instr_ready_o), 32'd1);
    drive(32'h402081B3, 32'h204);
    step();
    chk("bp_ready0", 32'(instr_ready_o), 32'd0);
    chk("bp_hold_a", pc_o, 32'h200);
    drive(32'h0033D313, 32'h208);
    step();
    chk("bp_stall_pc", pc_o, 32'h200);
    chk("bp_stall_op", 32'(alu_op_o), 32'(ALU_ADD));
    chk("bp_stall_ready", 32'(instr_ready_o), 32'd0);
    step();
    chk("bp_stall_pc2", pc_o, 32'h200);
    dec_ready_i = 1'b1;
    step();
    chk("bp_b_pc", pc_o, 32'h204);
    chk("bp_b_op", 32'(alu_op_o), 32'(ALU_SUB));
    chk("bp_ready_back", 32'(instr_ready_o), 32'd1);
    step();
    chk("bp_c_pc", pc_o, 32'h208);
    chk("bp_c_op", 32'(alu_op_o), 32'(ALU_SRL));
    instr_valid_i = 1'b0;
    step();
    chk("bp_empty", 32'(dec_valid_o), 32'd0);

    // Flush with both entries full and input valid.
    dec_ready_i = 1'b0;
    drive(32'h002081B3, 32'h300);
    step();
    drive(32'h002081B3, 32'h304);
    step();
    chk("fl_full", 32'(instr_ready_o), 32'd0);
    drive(32'h00000000, 32'h308);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    chk("fl1_valid", 32'(dec_valid_o), 32'd0);
    chk("fl1_ready", 32'(instr_ready_o), 32'd1);
    // Flush with main full and an accepted illegal input: dropped, not counted.
    drive(32'h002081B3, 32'h310);
    step();
    drive(32'h00000000, 32'h314);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    chk("fl2_valid", 32'(dec_valid_o), 32'd0);
    chk("fl2_cnt", 32'(illegal_cnt_o), 32'd3);
    step();
    chk("fl2_still_empty", 32'(dec_valid_o), 32'd0);

    // Saturation on the 2-bit counter instance.
    dec_ready_i = 1'b1;
    drive(32'hFFFFFFFF, 32'h400);
    step();
    instr_valid_i = 1'b0;
    chk("ones_illegal", 32'(illegal_o), 32'd1);
    chk("cnt4", 32'(illegal_cnt_o), 32'd4);
    chk("sat_hold", 32'(s_cnt), 32'd3);

    // Asynchronous reset mid-stream.
    dec_ready_i = 1'b0;
    drive(32'h002081B3, 32'h500);
    step();
    chk("pre_arst_valid", 32'(dec_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(dec_valid_o), 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_cnt", 32'(illegal_cnt_o), 32'd0);
    chk("arst_ready", 32'(instr_ready_o), 32'd1);
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    rst_ni = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
